icetap_capture_ctrl: RTL and testbench

- Sequencing controller for the icetap recording RAM. It runs the capture state machine: idle, fill pre-trigger window, wait for trigger, record post-trigger, then back to idle.
- Generates RAM write enable and address, and produces the start, trigger and stop addresses reported through the JTAG status register.
- Sits in the clk domain between the command synchronizer, the store/trigger qualifiers and the sample RAM.

---
 rtl/icetap_capture_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_icetap_capture_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/icetap_capture_ctrl.sv
// Capture sequencer for the icetap recording RAM: pre-trigger fill, trigger wait, post-trigger record.
// Optional trigger-occurrence counting is enabled by defining ICETAP_CTRL_TRIG_COUNT_EN.
module icetap_capture_ctrl #(
   parameter  int RECORD_DEPTH = 512,
   localparam int ADDR_BITS    = $clog2(RECORD_DEPTH)
) (
   input  logic                 clk,
   input  logic                 reset_,
   input  logic                 cmd_start,
   input  logic                 cmd_abort,
   input  logic [ADDR_BITS-1:0] pretrig_depth,
   input  logic                 store,
   input  logic                 trigger,
`ifdef ICETAP_CTRL_TRIG_COUNT_EN
   input  logic [7:0]           trig_count,
`endif
   output logic                 ram_wr_en,
   output logic [ADDR_BITS-1:0] ram_wr_addr,
   output logic                 status_idle,
   output logic [1:0]           status_state,
   output logic                 status_aborted,
   output logic [ADDR_BITS-1:0] status_start_addr,
   output logic [ADDR_BITS-1:0] status_trigger_addr,
   output logic [ADDR_BITS-1:0] status_stop_addr
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PRE  = 2'd1,
      S_WAIT = 2'd2,
      S_POST = 2'd3
   } state_t;

   localparam logic [ADDR_BITS-1:0] A_ZERO = ADDR_BITS'(0);
   localparam logic [ADDR_BITS-1:0] A_ONE  = ADDR_BITS'(1);
   localparam logic [ADDR_BITS:0]   C_ONE  = (ADDR_BITS+1)'(1);
   localparam logic [ADDR_BITS:0]   C_DEPTH = (ADDR_BITS+1)'(RECORD_DEPTH);

   state_t               r_state;
   logic [ADDR_BITS-1:0] r_p;
   logic [ADDR_BITS-1:0] r_wr_ptr;
   logic [ADDR_BITS-1:0] r_pre_cnt;
   logic [ADDR_BITS:0]   r_post_cnt;
   logic                 r_wrote;
   logic                 r_wr_en;
   logic [ADDR_BITS-1:0] r_wr_addr;
   logic                 r_aborted;
   logic [ADDR_BITS-1:0] r_start_addr;
   logic [ADDR_BITS-1:0] r_trig_addr;
   logic [ADDR_BITS-1:0] r_stop_addr;

   logic                 w_write;
   logic                 w_trig_accept;
   logic [ADDR_BITS-1:0] w_pre_next;
   logic [ADDR_BITS:0]   w_post_next;
   logic [ADDR_BITS:0]   w_post_target;

   // The port width already bounds pretrig_depth to RECORD_DEPTH-1, so the clamp is implicit.
   assign w_pre_next    = r_pre_cnt + A_ONE;
   assign w_post_next   = r_post_cnt + C_ONE;
   assign w_post_target = C_DEPTH - {1'b0, r_p};

`ifdef ICETAP_CTRL_TRIG_COUNT_EN
   logic [7:0] r_trig_n;
   logic [7:0] r_trig_cnt;
   assign w_trig_accept = trigger && ((r_trig_cnt + 8'd1) == r_trig_n);
`else
   assign w_trig_accept = trigger;
`endif

   // Decide whether the current sample is written; abort drops it.
   always_comb begin
      w_write = 1'b0;
      case (r_state)
         S_PRE:   w_write = store;
         S_WAIT:  w_write = store | w_trig_accept;
         S_POST:  w_write = store;
         default: w_write = 1'b0;
      endcase
      w_write = w_write & ~cmd_abort;
   end

   // Capture FSM, write pointer and status registers.
   always_ff @(posedge clk) begin
      if (!reset_) begin
         r_state      <= S_IDLE;
         r_p          <= A_ZERO;
         r_wr_ptr     <= A_ZERO;
         r_pre_cnt    <= A_ZERO;
         r_post_cnt   <= '0;
         r_wrote      <= 1'b0;
         r_wr_en      <= 1'b0;
         r_wr_addr    <= A_ZERO;
         r_aborted    <= 1'b0;
         r_start_addr <= A_ZERO;
         r_trig_addr  <= A_ZERO;
         r_stop_addr  <= A_ZERO;
`ifdef ICETAP_CTRL_TRIG_COUNT_EN
         r_trig_n     <= 8'd0;
         r_trig_cnt   <= 8'd0;
`endif
      end else begin
         r_wr_en <= w_write;
         if (w_write) begin
            r_wr_addr <= r_wr_ptr;
            r_wr_ptr  <= r_wr_ptr + A_ONE;
            r_wrote   <= 1'b1;
         end
         if (r_state == S_IDLE) begin
            if (cmd_start && !cmd_abort) begin
               r_p        <= pretrig_depth;
               r_wr_ptr   <= A_ZERO;
               r_pre_cnt  <= A_ZERO;
               r_post_cnt <= '0;
               r_wrote    <= 1'b0;
               r_aborted  <= 1'b0;
               r_state    <= (pretrig_depth == A_ZERO) ? S_WAIT : S_PRE;
`ifdef ICETAP_CTRL_TRIG_COUNT_EN
               r_trig_n   <= (trig_count == 8'd0) ? 8'd1 : trig_count;
               r_trig_cnt <= 8'd0;
`endif
            end
         end else if (cmd_abort) begin
            r_state     <= S_IDLE;
            r_aborted   <= 1'b1;
            r_stop_addr <= r_wrote ? (r_wr_ptr - A_ONE) : A_ZERO;
`ifdef ICETAP_CTRL_TRIG_COUNT_EN
            r_trig_cnt  <= 8'd0;
`endif
         end else begin
            case (r_state)
               S_PRE: begin
                  if (store) begin
                     r_pre_cnt <= w_pre_next;
                     if (w_pre_next == r_p) r_state <= S_WAIT;
                  end
               end
               S_WAIT: begin
                  if (w_trig_accept) begin
                     r_trig_addr  <= r_wr_ptr;
                     r_start_addr <= r_wr_ptr - r_p;
                     r_post_cnt   <= C_ONE;
                     // With a full pre-trigger window the trigger sample is the last one.
                     if (w_post_target == C_ONE) begin
                        r_stop_addr <= r_wr_ptr;
                        r_state     <= S_IDLE;
                     end else begin
                        r_state     <= S_POST;
                     end
`ifdef ICETAP_CTRL_TRIG_COUNT_EN
                  end else if (trigger) begin
                     r_trig_cnt <= r_trig_cnt + 8'd1;
`endif
                  end
               end
               S_POST: begin
                  if (store) begin
                     r_post_cnt <= w_post_next;
                     if (w_post_next == w_post_target) begin
                        r_stop_addr <= r_wr_ptr;
                        r_state     <= S_IDLE;
                     end
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign ram_wr_en           = r_wr_en;
   assign ram_wr_addr         = r_wr_addr;
   assign status_idle         = (r_state == S_IDLE);
   assign status_state        = r_state;
   assign status_aborted      = r_aborted;
   assign status_start_addr   = r_start_addr;
   assign status_trigger_addr = r_trig_addr;
   assign status_stop_addr    = r_stop_addr;

endmodule

// File: tb/tb_icetap_capture_ctrl.sv
// Directed self-checking bench for icetap_capture_ctrl (RECORD_DEPTH=512).
module tb_icetap_capture_ctrl;

   localparam int AB = 9;

   logic          clk = 1'b0;
   logic          reset_;
   logic          cmd_start;
   logic          cmd_abort;
   logic [AB-1:0] pretrig_depth;
   logic          store;
   logic          trigger;
`ifdef ICETAP_CTRL_TRIG_COUNT_EN
   logic [7:0]    trig_count;
`endif
   logic          ram_wr_en;
   logic [AB-1:0] ram_wr_addr;
   logic          status_idle;
   logic [1:0]    status_state;
   logic          status_aborted;
   logic [AB-1:0] status_start_addr;
   logic [AB-1:0] status_trigger_addr;
   logic [AB-1:0] status_stop_addr;

   int checks   = 0;
   int errors   = 0;
   int wr_count = 0;
   int addr_err = 0;

   always #5 clk = ~clk;

   icetap_capture_ctrl #(.RECORD_DEPTH(512)) dut (
      .clk                 (clk),
      .reset_              (reset_),
      .cmd_start           (cmd_start),
      .cmd_abort           (cmd_abort),
      .pretrig_depth       (pretrig_depth),
      .store               (store),
      .trigger             (trigger),
`ifdef ICETAP_CTRL_TRIG_COUNT_EN
      .trig_count          (trig_count),
`endif
      .ram_wr_en           (ram_wr_en),
      .ram_wr_addr         (ram_wr_addr),
      .status_idle         (status_idle),
      .status_state        (status_state),
      .status_aborted      (status_aborted),
      .status_start_addr   (status_start_addr),
      .status_trigger_addr (status_trigger_addr),
      .status_stop_addr    (status_stop_addr)
   );

   // Writes of one capture must land on consecutive addresses starting at 0.
   always @(negedge clk) begin
      if (ram_wr_en === 1'b1) begin
         if (ram_wr_addr !== wr_count[AB-1:0]) addr_err = addr_err + 1;
         wr_count = wr_count + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_until_idle(input string tag, input int budget);
      int n = 0;
      while (status_idle !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      chk(tag, {31'd0, status_idle}, 32'd1);
      tick();
   endtask

   initial begin
      reset_ = 1'b0; cmd_start = 1'b0; cmd_abort = 1'b0; pretrig_depth = '0;
      store = 1'b0; trigger = 1'b0;
`ifdef ICETAP_CTRL_TRIG_COUNT_EN
      trig_count = 8'd0;
`endif
      repeat (3) tick();
      chk("rst_idle", {31'd0, status_idle}, 32'd1);
      chk("rst_wr_en", {31'd0, ram_wr_en}, 32'd0);

      // Qualifiers without a command do nothing.
      reset_ = 1'b1; store = 1'b1; trigger = 1'b1;
      repeat (5) tick();
      chk("nocmd_writes", wr_count, 0);
      chk("nocmd_state", {30'd0, status_state}, 0);
      chk("nocmd_start", {23'd0, status_start_addr}, 0);
      chk("nocmd_trig", {23'd0, status_trigger_addr}, 0);
      chk("nocmd_stop", {23'd0, status_stop_addr}, 0);
      chk("nocmd_abort", {31'd0, status_aborted}, 0);

      // P=16, store every cycle, trigger on cycle 100 after start.
      wr_count = 0; addr_err = 0;
      for (int c = 0; c <= 100; c++) begin
         cmd_start = (c == 0); pretrig_depth = 9'd16; store = 1'b1; trigger = (c == 100);
         if (c == 16) chk("p16_still_pre", {30'd0, status_state}, 1);
         if (c == 17) chk("p16_wait", {30'd0, status_state}, 2);
         tick();
         if (c == 0) chk("p16_armed", {30'd0, status_state}, 1);
      end
      cmd_start = 1'b0; trigger = 1'b0;
      chk("p16_post", {30'd0, status_state}, 3);
      chk("p16_trig", {23'd0, status_trigger_addr}, 99);
      chk("p16_start", {23'd0, status_start_addr}, 83);
      run_until_idle("p16_done", 1000);
      chk("p16_writes", wr_count, 595);
      chk("p16_stop", {23'd0, status_stop_addr}, 82);
      chk("p16_aborted", {31'd0, status_aborted}, 0);
      chk("p16_addr_seq", addr_err, 0);

      // P=0, trigger in the first WAIT cycle with store low.
      wr_count = 0; addr_err = 0;
      cmd_start = 1'b1; pretrig_depth = 9'd0; store = 1'b0; trigger = 1'b0;
      tick();
      cmd_start = 1'b0;
      chk("p0_wait", {30'd0, status_state}, 2);
      trigger = 1'b1;
      tick();
      trigger = 1'b0; store = 1'b1;
      chk("p0_post", {30'd0, status_state}, 3);
      chk("p0_trig", {23'd0, status_trigger_addr}, 0);
      chk("p0_start", {23'd0, status_start_addr}, 0);
      run_until_idle("p0_done", 1000);
      chk("p0_writes", wr_count, 512);
      chk("p0_stop", {23'd0, status_stop_addr}, 511);
      chk("p0_addr_seq", addr_err, 0);

      // P=511: trigger sample is the final write of the capture.
      wr_count = 0; addr_err = 0;
      for (int c = 0; c <= 532; c++) begin
         cmd_start = (c == 0); pretrig_depth = 9'd511; store = 1'b1; trigger = (c == 532);
         if (c == 511) chk("p511_pre", {30'd0, status_state}, 1);
         if (c == 512) chk("p511_wait", {30'd0, status_state}, 2);
         tick();
      end
      cmd_start = 1'b0; trigger = 1'b0; store = 1'b0;
      chk("p511_idle", {31'd0, status_idle}, 1);
      chk("p511_trig", {23'd0, status_trigger_addr}, 19);
      chk("p511_start", {23'd0, status_start_addr}, 20);
      chk("p511_stop", {23'd0, status_stop_addr}, 19);
      tick();
      chk("p511_writes", wr_count, 532);
      chk("p511_addr_seq", addr_err, 0);

      // Abort on the 5th WAIT cycle (with a trigger), plus a cmd_start while busy.
      wr_count = 0; addr_err = 0;
      for (int c = 0; c <= 7; c++) begin
         cmd_start = (c == 0) || (c == 3); pretrig_depth = (c == 0) ? 9'd2 : 9'd7;
         store = 1'b1; trigger = (c == 7); cmd_abort = (c == 7);
         if (c == 4) chk("abort_wait", {30'd0, status_state}, 2);
         tick();
      end
      cmd_start = 1'b0; cmd_abort = 1'b0; trigger = 1'b0;
      chk("abort_idle", {31'd0, status_idle}, 1);
      chk("abort_flag", {31'd0, status_aborted}, 1);
      chk("abort_stop", {23'd0, status_stop_addr}, 5);
      chk("abort_trig_kept", {23'd0, status_trigger_addr}, 19);
      chk("abort_start_kept", {23'd0, status_start_addr}, 20);
      repeat (5) tick();
      chk("abort_writes", wr_count, 6);
      chk("abort_addr_seq", addr_err, 0);
      store = 1'b0;

      // Start and abort together while idle: abort wins, nothing is armed or cleared.
      cmd_start = 1'b1; cmd_abort = 1'b1; pretrig_depth = 9'd4;
      tick();
      cmd_start = 1'b0; cmd_abort = 1'b0;
      chk("startabort_state", {30'd0, status_state}, 0);
      chk("startabort_flag", {31'd0, status_aborted}, 1);

      // Reset asserted mid-capture.
      cmd_start = 1'b1; pretrig_depth = 9'd4; store = 1'b1;
      tick();
      cmd_start = 1'b0;
      repeat (2) tick();
      chk("midrst_pre", {30'd0, status_state}, 1);
      reset_ = 1'b0;
      tick();
      reset_ = 1'b1; store = 1'b0;
      chk("midrst_idle", {31'd0, status_idle}, 1);
      chk("midrst_wr_en", {31'd0, ram_wr_en}, 0);
      chk("midrst_wr_addr", {23'd0, ram_wr_addr}, 0);
      chk("midrst_aborted", {31'd0, status_aborted}, 0);
      chk("midrst_stop", {23'd0, status_stop_addr}, 0);
      chk("midrst_trig", {23'd0, status_trigger_addr}, 0);
      chk("midrst_start", {23'd0, status_start_addr}, 0);

`ifdef ICETAP_CTRL_TRIG_COUNT_EN
      // Third trigger pulse is the real one; earlier pulses with store low are not written.
      tick();
      wr_count = 0; addr_err = 0;
      cmd_start = 1'b1; pretrig_depth = 9'd0; trig_count = 8'd3;
      tick();
      cmd_start = 1'b0;
      trigger = 1'b1; store = 1'b0; tick();
      trigger = 1'b0; store = 1'b1; tick();
      trigger = 1'b1; store = 1'b0; tick();
      chk("tc_still_wait", {30'd0, status_state}, 2);
      trigger = 1'b0; store = 1'b1; tick();
      trigger = 1'b1; store = 1'b0; tick();
      trigger = 1'b0;
      chk("tc_post", {30'd0, status_state}, 3);
      chk("tc_trig", {23'd0, status_trigger_addr}, 2);
      tick();
      chk("tc_writes", wr_count, 3);
      chk("tc_addr_seq", addr_err, 0);
      cmd_abort = 1'b1; tick(); cmd_abort = 1'b0;
      chk("tc_idle", {31'd0, status_idle}, 1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
